// File: rtl/simple_mem_arb_pkg.sv
// Shared definitions for the SIMPLE CPU memory-port arbiter:
// requester indices and the FSM state encoding.
package simple_mem_arb_pkg;

    localparam int NUM_REQ   = 3;
    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_EXT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_prio_sel.sv
// Combinational fixed-priority picker (data > fetch > ext); a raised
// starve flag lifts a pending ext request above everything else.
module mem_arb_prio_sel
    import simple_mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               starve_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic               valid_o
);

    always_comb begin
        win_o = '0;
        if (starve_i && req_i[REQ_EXT]) begin
            win_o[REQ_EXT] = 1'b1;
        end else if (req_i[REQ_DATA]) begin
            win_o[REQ_DATA] = 1'b1;
        end else if (req_i[REQ_FETCH]) begin
            win_o[REQ_FETCH] = 1'b1;
        end else if (req_i[REQ_EXT]) begin
            win_o[REQ_EXT] = 1'b1;
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch, data and external requesters.
// Optional ext anti-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no transaction; requests sampled and winner latched
// ST_ACCESS | address cycle: gnt pulse, mem_we for writes, counter load
// ST_WAIT   | address held; done pulse in the cycle the counter hits 0
module mem_port_arbiter
    import simple_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          done_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    output logic                        mem_we_o,
    input  logic [DATA_W-1:0]           mem_rdata_i,
    output logic                        busy_o
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT must be within 1..4");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
    end

    arb_state_e          state_q;
    logic [NUM_REQ-1:0]  win_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [2:0]          cnt_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                mem_we_q;

    logic [NUM_REQ-1:0]  sel_win;
    logic                sel_valid;
    logic                starve;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    mem_arb_prio_sel u_prio_sel (
        .req_i    (req_i),
        .starve_i (starve),
        .win_o    (sel_win),
        .valid_o  (sel_valid)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_win[i]) begin
                sel_we    = we_i[i];
                sel_addr  = addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] starve_cnt_q;
    logic [SC_W-1:0] starve_cnt_d;

    // Only IDLE cycles count as waiting; a dropped ext request forgets its history.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!req_i[REQ_EXT] || (state_q == ST_IDLE && sel_win[REQ_EXT])) begin
            starve_cnt_d = '0;
        end else if (state_q == ST_IDLE && starve_cnt_q < SC_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign starve = (starve_cnt_q >= SC_W'(STARVE_LIMIT));
`else
    assign starve = 1'b0;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            mem_we_q <= 1'b0;
        end else begin
            gnt_q    <= '0;
            done_q   <= '0;
            mem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        state_q  <= ST_ACCESS;
                        win_q    <= sel_win;
                        we_q     <= sel_we;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        gnt_q    <= sel_win;
                        mem_we_q <= sel_we;
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_WAIT;
                    cnt_q   <= 3'(RD_LAT - 1);
                    if (RD_LAT == 1) begin
                        done_q <= win_q;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                        // Raise done one edge early so it lands on the cnt==0 cycle.
                        if (cnt_q == 3'd1) begin
                            done_q <= win_q;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign rdata_o     = mem_rdata_i;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_we_o    = mem_we_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
